// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one downstream port between fetch (A)
// and data (B), one outstanding transaction, alternating on ties.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_a,
  input  logic [15:0] address_a,
  input  logic        flush_a,
  output logic        resp_a,
  output logic [15:0] rdata_a,
  input  logic        read_b,
  input  logic        write_b,
  input  logic [15:0] address_b,
  input  logic [15:0] wdata_b,
  input  logic [1:0]  wmask_b,
  output logic        resp_b,
  output logic [15:0] rdata_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_A = 2'd1;
  localparam logic [1:0] SERVE_B = 2'd2;
  localparam logic [1:0] WAIT    = 2'd3;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        last_grant;
  logic        discard_a;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [1:0]  lat_mask;
  logic        lat_write;

  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;

  assign req_a = read_a;
  assign req_b = read_b | write_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      if (req_a && req_b) begin
        grant_b = (last_grant == GRANT_A);
        grant_a = ~grant_b;
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_a)      state_nxt = SERVE_A;
        else if (grant_b) state_nxt = SERVE_B;
      end
      SERVE_A,
      SERVE_B: if (mem_resp) state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_A;
      discard_a  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_mask   <= '0;
      lat_write  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_a) begin
        last_grant <= GRANT_A;
        lat_addr   <= address_a;
        lat_wdata  <= '0;
        lat_mask   <= 2'b11;
        lat_write  <= 1'b0;
      end else if (grant_b) begin
        last_grant <= GRANT_B;
        lat_addr   <= address_b;
        lat_wdata  <= wdata_b;
        lat_mask   <= write_b ? wmask_b : 2'b11;
        lat_write  <= write_b;
      end
      // A flush may arrive any time during the fetch; remember it
      if (state == SERVE_A)
        discard_a <= mem_resp ? 1'b0 : (discard_a | flush_a);
    end
  end

  assign mem_read  = (state == SERVE_A) |
                     ((state == SERVE_B) & ~lat_write);
  assign mem_write = (state == SERVE_B) & lat_write;

  assign mem_address     = lat_addr;
  assign mem_wdata       = lat_wdata;
  assign mem_byte_enable = lat_mask;

  assign resp_a = (state == SERVE_A) & mem_resp &
                  ~(discard_a | flush_a);
  assign resp_b = (state == SERVE_B) & mem_resp;

  assign rdata_a = mem_rdata;
  assign rdata_b = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps, a small memory
// responder and a response scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_a;
  logic [15:0] address_a;
  logic        flush_a;
  logic        resp_a;
  logic [15:0] rdata_a;
  logic        read_b;
  logic        write_b;
  logic [15:0] address_b;
  logic [15:0] wdata_b;
  logic [1:0]  wmask_b;
  logic        resp_b;
  logic [15:0] rdata_b;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        port;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];

  mem_port_arbiter dut (
    .clk(clk),
    .reset(reset),
    .read_a(read_a),
    .address_a(address_a),
    .flush_a(flush_a),
    .resp_a(resp_a),
    .rdata_a(rdata_a),
    .read_b(read_b),
    .write_b(write_b),
    .address_b(address_b),
    .wdata_b(wdata_b),
    .wmask_b(wmask_b),
    .resp_b(resp_b),
    .rdata_b(rdata_b),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic [15:0] d);
    exp_t e;
    e.port = port;
    e.data = d;
    sb.push_back(e);
  endtask

  // Every response the DUT produces must match the next expected one.
  always @(negedge clk) begin
    if (resp_a || resp_b) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_resp", {30'd0, resp_a, resp_b}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_port_a", resp_a, !e.port);
        chk("sb_port_b", resp_b, e.port);
        chk("sb_data", resp_b ? rdata_b : rdata_a, e.data);
      end
    end
  end

  // Memory responder: wait for a strobe, check it each cycle, answer
  // after `delay` cycles, then check the release cycle is quiet.
  task automatic serve(input logic        exp_w,
                       input logic [15:0] exp_addr,
                       input logic [15:0] exp_wd,
                       input logic [1:0]  exp_be,
                       input int          delay,
                       input logic [15:0] data,
                       input int          flush_at,
                       input bit          scramble,
                       output int         lat);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(mem_read || mem_write) && n < 20);
    lat = n;
    if (!(mem_read || mem_write)) begin
      chk("strobe_timeout", {31'd0, mem_read | mem_write}, 32'd1);
      return;
    end
    for (int i = 0; i <= delay; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      mem_resp  = (i == delay);
      mem_rdata = (i == delay) ? data : 16'h0000;
      flush_a   = (i == flush_at);
      if (scramble && i == 0) begin
        address_a = 16'h0000;
        address_b = 16'h0000;
        wdata_b   = 16'h0000;
      end
      @(negedge clk);
      chk("strobe_rd", mem_read, !exp_w);
      chk("strobe_wr", mem_write, exp_w);
      chk("mem_addr", mem_address, exp_addr);
      chk("mem_be", mem_byte_enable, exp_be);
      if (exp_w) chk("mem_wdata", mem_wdata, exp_wd);
    end
    @(posedge clk); #1;
    mem_resp = 1'b0;
    flush_a  = 1'b0;
    @(negedge clk);
    chk("wait_no_rd", mem_read, 1'b0);
    chk("wait_no_wr", mem_write, 1'b0);
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  task automatic single(input logic port_b, input int i);
    int lat;
    logic [15:0] a;
    logic [15:0] d;
    a = port_b ? 16'h2100 + 16'(i) : 16'h1100 + 16'(i);
    d = port_b ? 16'hB100 + 16'(i) : 16'hA100 + 16'(i);
    if (port_b) begin
      read_b = 1'b1; address_b = a;
    end else begin
      read_a = 1'b1; address_a = a;
    end
    push(port_b, d);
    serve(1'b0, a, 16'h0, 2'b11, 1, d, -1, 1'b0, lat);
    read_a = 1'b0;
    read_b = 1'b0;
    gap();
  endtask

  task automatic tie(input logic first_b, input int i);
    int lat;
    logic [15:0] aa;
    logic [15:0] ab;
    logic [15:0] da;
    logic [15:0] db;
    aa = 16'h1000 + 16'(i * 2);
    ab = 16'h2000 + 16'(i * 2);
    da = 16'hA000 + 16'(i);
    db = 16'hB000 + 16'(i);
    read_a = 1'b1; address_a = aa;
    read_b = 1'b1; address_b = ab;
    if (first_b) begin
      push(1'b1, db);
      push(1'b0, da);
      serve(1'b0, ab, 16'h0, 2'b11, 0, db, -1, 1'b0, lat);
      read_b = 1'b0;
      serve(1'b0, aa, 16'h0, 2'b11, 1, da, -1, 1'b0, lat);
      read_a = 1'b0;
    end else begin
      push(1'b0, da);
      push(1'b1, db);
      serve(1'b0, aa, 16'h0, 2'b11, 0, da, -1, 1'b0, lat);
      read_a = 1'b0;
      serve(1'b0, ab, 16'h0, 2'b11, 1, db, -1, 1'b0, lat);
      read_b = 1'b0;
    end
    gap();
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    read_a = 1'b0; address_a = '0; flush_a = 1'b0;
    read_b = 1'b0; write_b = 1'b0; address_b = '0;
    wdata_b = '0; wmask_b = '0;
    mem_resp = 1'b0; mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_resp_a", resp_a, 1'b0);
    chk("rst_resp_b", resp_b, 1'b0);
    chk("rst_mem_addr", mem_address, 16'h0);
    chk("rst_mem_be", mem_byte_enable, 2'b00);

    // single fetch
    gap();
    read_a = 1'b1; address_a = 16'h3000;
    push(1'b0, 16'h1234);
    serve(1'b0, 16'h3000, 16'h0, 2'b11, 2, 16'h1234, -1, 1'b0, lat);
    chk("fetch_latency", lat, 1);
    read_a = 1'b0;
    gap();

    // alternating ties
    for (int i = 0; i < 4; i++) begin
      tie(i % 2 == 0, i);
      single(i % 2 == 0, i);
    end

    // write path, requester changes inputs after the grant
    write_b = 1'b1; address_b = 16'h4002;
    wdata_b = 16'hBEEF; wmask_b = 2'b10;
    push(1'b1, 16'h5A5A);
    serve(1'b1, 16'h4002, 16'hBEEF, 2'b10, 3, 16'h5A5A, -1, 1'b1, lat);
    write_b = 1'b0;
    gap();

    // read and write together count as a write
    read_b = 1'b1; write_b = 1'b1; address_b = 16'h4100;
    wdata_b = 16'h0F0F; wmask_b = 2'b01;
    push(1'b1, 16'h0001);
    serve(1'b1, 16'h4100, 16'h0F0F, 2'b01, 1, 16'h0001, -1, 1'b0, lat);
    read_b = 1'b0; write_b = 1'b0;
    gap();

    // flush mid-transaction, then a normal fetch
    read_a = 1'b1; address_a = 16'h3100;
    serve(1'b0, 16'h3100, 16'h0, 2'b11, 3, 16'hDEAD, 1, 1'b0, lat);
    read_a = 1'b0;
    gap();
    read_a = 1'b1; address_a = 16'h3102;
    push(1'b0, 16'h7777);
    serve(1'b0, 16'h3102, 16'h0, 2'b11, 1, 16'h7777, -1, 1'b0, lat);
    read_a = 1'b0;
    gap();

    // flush coincident with mem_resp, then a normal fetch
    read_a = 1'b1; address_a = 16'h3200;
    serve(1'b0, 16'h3200, 16'h0, 2'b11, 3, 16'hDEAD, 3, 1'b0, lat);
    read_a = 1'b0;
    gap();
    read_a = 1'b1; address_a = 16'h3202;
    push(1'b0, 16'h8888);
    serve(1'b0, 16'h3202, 16'h0, 2'b11, 0, 16'h8888, -1, 1'b0, lat);
    read_a = 1'b0;
    gap();

    // reset during SERVE_B, stray mem_resp afterwards
    read_b = 1'b1; address_b = 16'h5000;
    @(posedge clk); #1;
    chk("pre_rst_strobe", mem_read, 1'b1);
    reset = 1'b1;
    read_b = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd", mem_read, 1'b0);
    chk("mid_rst_wr", mem_write, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    mem_resp = 1'b1; mem_rdata = 16'hBAD0;
    @(negedge clk);
    chk("stray_resp_a", resp_a, 1'b0);
    chk("stray_resp_b", resp_b, 1'b0);
    chk("stray_rd", mem_read, 1'b0);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    read_a = 1'b1; address_a = 16'h3300;
    push(1'b0, 16'h4321);
    serve(1'b0, 16'h3300, 16'h0, 2'b11, 1, 16'h4321, -1, 1'b0, lat);
    chk("post_rst_idle_latency", lat, 1);

    // read_a held one cycle past resp_a: no second service
    @(posedge clk); #1;
    read_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_double_rd", mem_read, 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single physical memory port between the instruction-fetch port (port A, read-only) and the data-access port (port B, read/write) of the pipelined LC-3b core. It sits between the fetch/memory stages and the memory model or cache. Each grant owns the port until completion, so the port carries one outstanding transaction at a time. Ties alternate between A and B so neither stage starves, and a fetch flush discards a stale instruction response without aborting the memory transaction.

## Interface
Parameters: none; all widths are fixed by lc3b_types (lc3b_word = 16 bits).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- read_a  in  1  fetch read request; level, held until resp_a
- address_a  in  16  fetch word address
- flush_a  in  1  fetch redirect (branch/jmp/trap); discard the in-flight fetch response
- resp_a  out  1  fetch transaction complete; one-cycle pulse
- rdata_a  out  16  fetch read data; valid when resp_a=1
- read_b  in  1  data read request; level, held until resp_b
- write_b  in  1  data write request; level, held until resp_b
- address_b  in  16  data address
- wdata_b  in  16  data write value
- wmask_b  in  2  byte enables for write_b ([1]=high byte)
- resp_b  out  1  data transaction complete; one-cycle pulse
- rdata_b  out  16  data read data; valid when resp_b=1
- mem_read  out  1  downstream read strobe; level
- mem_write  out  1  downstream write strobe; level
- mem_address  out  16  downstream address
- mem_wdata  out  16  downstream write data
- mem_byte_enable  out  2  downstream byte enables (2'b11 for reads)
- mem_resp  in  1  downstream completion; one-cycle pulse
- mem_rdata  in  16  downstream read data; valid with mem_resp

## Operation
- States: IDLE, SERVE_A, SERVE_B, WAIT (one-cycle release).
- Registers:
  - state
  - last_grant (A/B)
  - discard_a
  - latched request: address, wdata, mask, is_write
- IDLE:
  - Only A requesting -> SERVE_A.
  - Only B (read_b or write_b) requesting -> SERVE_B.
  - Both requesting -> grant the port != last_grant.
  - Granting latches that port's address, wdata, mask and type, and updates last_grant.
- read_b and write_b both high: treated as a write.
- SERVE_x: mem_read or mem_write is asserted from state, and mem_address/mem_wdata/mem_byte_enable come from the latched registers. Requester changes to address or data after the grant are ignored.
- On mem_resp in SERVE_x:
  - resp_x=1 the same cycle (combinational), with rdata_x=mem_rdata.
  - Next state is WAIT.
- WAIT:
  - All mem strobes are 0 and no grant is made, so a requester that is still high in the resp cycle is not re-served.
  - Next state is IDLE.
- flush_a:
  - High in SERVE_A, including the mem_resp cycle: sets discard_a.
  - On completion with discard_a set: resp_a forced to 0, then discard_a is cleared.
  - In IDLE/WAIT/SERVE_B: no effect.
- rdata_a and rdata_b always pass mem_rdata through; only the resp signals qualify them.
- Reset:
  - state=IDLE, last_grant=A (first tie goes to B), discard_a=0, latched registers=0.
  - Outputs: mem_read=0, mem_write=0, resp_a=0, resp_b=0, mem_address=0, mem_byte_enable=0.
  - Reset mid-transaction drops the strobes and abandons the transaction; a later stray mem_resp is ignored in IDLE/WAIT.

## Timing
- A request seen in IDLE at edge t: strobe high in cycle t+1.
- mem_resp in cycle k: resp in cycle k, strobe low from k+1 (WAIT), IDLE at k+2.
- Earliest next grant is sampled at edge k+2, with its strobe in k+3.
- Minimum request-to-resp latency is 1 cycle (mem_resp in the first strobe cycle).
- Back-to-back service of two ports costs 2 idle cycles between transactions.
- mem_resp outside SERVE_A/SERVE_B is ignored.
- Strobes are never asserted in IDLE or WAIT.

## Test plan
- **Single fetch.** read_a=1, address_a=0x3000; memory answers 2 cycles after the strobe with 0x1234.
  - mem_read=1, mem_address=0x3000, mem_byte_enable=11.
  - resp_a=1 with rdata_a=0x1234 in the mem_resp cycle.
  - mem_read=0 the next cycle.
- **Tie after reset.** read_a and read_b high together in IDLE.
  - B served first, then A.
  - A second simultaneous tie after that grants A then B (alternation verified over 4 ties).
- **Write path.** write_b=1, address_b=0x4002, wdata_b=0xBEEF, wmask_b=10; address_b changed to 0x0000 after the grant.
  - mem_write=1, mem_address stays 0x4002, mem_byte_enable=10, mem_wdata=0xBEEF until mem_resp.
  - resp_b pulses for one cycle.
- **Flush.**
  - flush_a pulsed mid-SERVE_A: transaction completes downstream, resp_a stays 0, the next read_a is then served normally with resp_a=1.
  - Repeat with flush_a coincident with mem_resp: resp_a=0.
- **Reset mid-transaction.** reset asserted during SERVE_B, then mem_resp pulsed 3 cycles after reset drops.
  - Strobes are 0 the cycle after reset.
  - resp_a and resp_b remain 0.
  - State is IDLE.
- **No double service.** read_a held high for one cycle past resp_a.
  - Exactly one mem_read transaction occurs; no strobe in the WAIT cycle.
